div: RTL and testbench
======================

DIV -- requirements
Module: div

Interface
REQ-001 Parameter NUM, default 4: output period in clk_sig cycles, integer >= 1.
REQ-002 Parameter DUTY, default 2: output high time in clk_sig cycles per period, integer >= 0.
REQ-003 clk_sig  input  1  sole clock; all state changes on the rising edge, except the REQ-022 falling-edge stage.
REQ-004 rst_sig  input  1  asynchronous, active-low reset.
REQ-005 div_sig  output  1  divided clock: period NUM clk_sig cycles, high for DUTY cycles.

Function
REQ-006 Internal phase counter cnt, width max(1, clog2(NUM)), counts 0..NUM-1.
REQ-007 Every rising clk_sig edge out of reset: cnt_next = 0 if cnt == NUM-1, else cnt+1; cnt <= cnt_next.
REQ-008 Output register pos_q <= (cnt_next < DUTY) on the same edge; div_sig is driven from a register, never combinationally from cnt.
REQ-009 First rising edge after reset release: cnt = 0 and pos_q = (DUTY > 0). The output period starts on this edge.
REQ-010 Steady state: div_sig high for exactly DUTY clk_sig cycles, then low for NUM-DUTY cycles, repeating with period NUM.
REQ-011 DUTY = 0: div_sig constant 0.
REQ-012 DUTY >= NUM: div_sig 1 from the first edge after reset and stays 1. DUTY is clipped to NUM internally.
REQ-013 NUM = 1: counter held at 0; div_sig = (DUTY > 0) after the first edge.
REQ-014 NUM = 0 is illegal: elaboration fails with an error message.
REQ-015 Counter wrap: cnt never takes a value >= NUM. Non-power-of-two NUM wraps at NUM-1, not at the counter's full range.
REQ-016 Reset asserted mid-period: div_sig drops to 0 immediately, with no clock required. The period restarts per REQ-009 after release.

Reset
REQ-017 While rst_sig = 0: cnt = NUM-1, pos_q = 0, neg_q = 0, div_sig = 0.
REQ-018 Reset assertion is asynchronous. Release takes effect on the first rising clk_sig edge with rst_sig = 1.
REQ-019 div_sig has no X or glitch after reset, from reset through the first edge.

Configuration
REQ-020 Macro DIV_HALF_CYCLE_EN selects half-cycle duty extension.
REQ-021 Without DIV_HALF_CYCLE_EN: div_sig = pos_q, and no falling-edge logic exists.
REQ-022 With DIV_HALF_CYCLE_EN, neg_q samples pos_q on each falling clk_sig edge, under the same asynchronous reset.
REQ-023 With DIV_HALF_CYCLE_EN, div_sig = pos_q OR neg_q, and high time becomes DUTY + 0.5 clk_sig cycles when 0 < DUTY < NUM.
REQ-024 With DIV_HALF_CYCLE_EN, setting NUM = 5 and DUTY = 2 gives an exact 50% duty output.
REQ-025 With DIV_HALF_CYCLE_EN, DUTY = 0 and DUTY >= NUM behave exactly as in REQ-011 and REQ-012.

Verification
REQ-026 Default case: NUM=4, DUTY=2, clk period 50 ns, first rising edge at 25 ns, rst_sig released at 100 ns -> div_sig rises at 125 ns, falls at 225 ns, rises at 325 ns; period 200 ns, 50% duty, sustained to 10 us.
REQ-027 Non-power-of-two: NUM=5, DUTY=1 -> high 1 cycle, low 4 cycles; cnt never reaches 5.
REQ-028 Extremes: DUTY=0 -> div_sig constant 0. DUTY=7 with NUM=4 -> div_sig constant 1 after the first edge.
REQ-029 Mid-period reset: assert rst_sig low between clock edges while div_sig = 1 -> div_sig = 0 within the same time step; after release, div_sig rises on the first edge.
REQ-030 DIV_HALF_CYCLE_EN defined, NUM=5, DUTY=2 -> high 125 ns, low 125 ns at a 50 ns clock period.

Source files
------------

// File: rtl/div.sv
// ============================================================================
// Module   : div
// Purpose  : Integer clock divider. Produces div_sig with a period of NUM
//            clk_sig cycles, high for DUTY cycles of each period. The output
//            always comes straight from a register.
// Ports    : clk_sig  in   sole clock (rising edge, plus falling edge for the
//                          optional half-cycle stage)
//            rst_sig  in   asynchronous active-low reset
//            div_sig  out  divided clock
// Params   : NUM  (>=1) period in clk_sig cycles
//            DUTY (>=0) high time in clk_sig cycles, clipped to NUM
// Config   : DIV_HALF_CYCLE_EN - when defined, a falling-edge register
//            stretches the high time by half a clk_sig cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div #(
    parameter int NUM  = 4,
    parameter int DUTY = 2
) (
    input  logic clk_sig,
    input  logic rst_sig,
    output logic div_sig
);

    localparam int              C_CW      = (NUM > 1) ? $clog2(NUM) : 1;
    localparam int              C_DUTY    = (DUTY > NUM) ? NUM : DUTY;
    localparam logic [C_CW-1:0] C_CNT_MAX = C_CW'(NUM - 1);
    localparam logic [31:0]     C_DUTY_U  = 32'(C_DUTY);

    generate
        if (NUM < 1) begin : g_num_check
            $error("div: NUM must be >= 1 (got %0d)", NUM);
        end
    endgenerate

    logic [C_CW-1:0] cnt_q;
    logic [C_CW-1:0] cnt_d;
    logic            pos_q;
    logic            pos_d;
    logic [31:0]     cnt_ext;

    // Wrap explicitly at NUM-1 so non-power-of-two periods never reach the
    // counter's full binary range.
    always_comb begin
        cnt_d = cnt_q + C_CW'(1);
        if (cnt_q == C_CNT_MAX) begin
            cnt_d = '0;
        end
    end

    // The output is registered from the *next* phase so that the edge which
    // loads phase 0 also raises div_sig.
    assign cnt_ext = 32'(cnt_d);
    assign pos_d   = (cnt_ext < C_DUTY_U);

    // Reset parks the counter at NUM-1 so the first edge after release lands
    // on phase 0 and starts a fresh period.
    always_ff @(posedge clk_sig or negedge rst_sig) begin
        if (!rst_sig) begin
            cnt_q <= C_CNT_MAX;
            pos_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pos_q <= pos_d;
        end
    end

`ifdef DIV_HALF_CYCLE_EN
    logic neg_q;

    // Delayed copy of pos_q by half a clock; ORing it in extends each high
    // pulse by half a cycle. Constant-0 and constant-1 outputs are unaffected.
    always_ff @(negedge clk_sig or negedge rst_sig) begin
        if (!rst_sig) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= pos_q;
        end
    end

    assign div_sig = pos_q | neg_q;
`else
    assign div_sig = pos_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_div.sv
// ============================================================================
// Module   : tb_div
// Purpose  : Self-checking bench for div. Several parameterisations run side
//            by side against a phase-arithmetic model of the divided clock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div;

    localparam int N_INST = 7;
    localparam int NUMS  [N_INST] = '{4, 5, 4, 4, 1, 5, 3};
    localparam int DUTYS [N_INST] = '{2, 1, 0, 7, 1, 2, 2};

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [N_INST-1:0] d;

    int total = 0;
    int bad   = 0;
    int k     = 0;   // rising edges seen since reset release

    genvar gi;
    generate
        for (gi = 0; gi < N_INST; gi++) begin : g_dut
            div #(
                .NUM  (NUMS[gi]),
                .DUTY (DUTYS[gi])
            ) u_dut (
                .clk_sig (clk),
                .rst_sig (rst),
                .div_sig (d[gi])
            );
        end
    endgenerate

    // Rising edges at 25, 75, 125 ns ...
    initial begin
        forever begin
            #25 clk = 1'b1;
            #25 clk = 1'b0;
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    // Level of pos_q after the n-th rising edge since release: the period
    // starts at edge 1, high while the phase is below the clipped duty.
    function automatic logic pos_level(input int inst, input int n);
        int dc;
        if (n <= 0) return 1'b0;
        dc = (DUTYS[inst] > NUMS[inst]) ? NUMS[inst] : DUTYS[inst];
        return ((n - 1) % NUMS[inst]) < dc;
    endfunction

    function automatic logic exp_after_rise(input int inst, input int n);
`ifdef DIV_HALF_CYCLE_EN
        return pos_level(inst, n) | pos_level(inst, n - 1);
`else
        return pos_level(inst, n);
`endif
    endfunction

    always @(posedge clk) begin
        if (rst) k = k + 1;
        else     k = 0;
        #1;
        for (int i = 0; i < N_INST; i++) begin
            check($sformatf("rise_div%0d", i), d[i],
                  rst ? exp_after_rise(i, k) : 1'b0);
        end
        check("cnt_n5_lt5", g_dut[1].u_dut.cnt_q < 3'd5, 1'b1);
        check("cnt_n3_lt3", g_dut[6].u_dut.cnt_q < 2'd3, 1'b1);
    end

    always @(negedge clk) begin
        #1;
        for (int i = 0; i < N_INST; i++) begin
            check($sformatf("fall_div%0d", i), d[i],
                  rst ? pos_level(i, k) : 1'b0);
        end
    end

    initial begin
        // Reset state, including across a rising edge held in reset.
        #10;
        for (int i = 0; i < N_INST; i++) check($sformatf("rst0_div%0d", i), d[i], 1'b0);
        #50;  // 60 ns
        for (int i = 0; i < N_INST; i++) check($sformatf("rst1_div%0d", i), d[i], 1'b0);
        #40 rst = 1'b1;   // released at 100 ns

        // Hand-computed edges of the default divider and NUM=5 variants.
        #24;  // 124
        check("lit_124_div0", d[0], 1'b0);
        #2;   // 126
        check("lit_126_div0", d[0], 1'b1);
        check("lit_126_n5d1", d[1], 1'b1);
        check("lit_126_d7",   d[3], 1'b1);
        #48;  // 174
        check("lit_174_n5d1", d[1], 1'b1);
        #2;   // 176
        check("lit_176_n5d1", d[1], 1'b0);
        #48;  // 224
        check("lit_224_div0", d[0], 1'b1);
        #2;   // 226
`ifdef DIV_HALF_CYCLE_EN
        check("lit_226_div0", d[0], 1'b1);
        check("lit_226_n5d2", d[5], 1'b1);
        #23;  // 249
        check("lit_249_n5d2", d[5], 1'b1);
        #2;   // 251
        check("lit_251_div0", d[0], 1'b0);
        check("lit_251_n5d2", d[5], 1'b0);
        #75;  // 326
`else
        check("lit_226_div0", d[0], 1'b0);
        check("lit_226_n5d2", d[5], 1'b0);
        #100; // 326
`endif
        check("lit_326_div0", d[0], 1'b1);
        check("lit_326_d0",   d[2], 1'b0);

        // Sustain to 10 us without reset.
        #(10000 - 326);

        // Random run lengths with asynchronous mid-period resets.
        for (int seg = 0; seg < 20; seg++) begin
            repeat ($urandom_range(5, 40)) @(posedge clk);
            #10 rst = 1'b0;
            #1;
            for (int i = 0; i < N_INST; i++) check($sformatf("async_rst_div%0d", i), d[i], 1'b0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            @(posedge clk);
            #30 rst = 1'b1;
        end

        repeat (12) @(posedge clk);
        #5;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
